// File: rtl/cv32e40p_instr_obi_arbiter.sv
// ============================================================================
// Module   : cv32e40p_instr_obi_arbiter
// Purpose  : Shares one instruction-side OBI port between two fetch masters
//            (m0 = prefetch buffer, m1 = secondary fetcher). The selection
//            stays on a waited request until it is granted. An ID FIFO of
//            outstanding transactions steers each response back to the
//            master that issued it.
// Ports    : clk, rst (synchronous, active high)
//            m0_*/m1_* : req/addr in; gnt/rvalid/rdata/err out
//            obi_*     : shared bus req/addr out; gnt/rvalid/rdata/err in
//            outstanding_o, busy_o, protocol_err_o (sticky) status
// Config   : CV32E40P_INSTR_ARB_RR_EN defined   -> round-robin arbitration
//            CV32E40P_INSTR_ARB_RR_EN undefined -> fixed priority, m0 wins
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cv32e40p_instr_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               m0_req_i,
  input  logic [31:0]                        m0_addr_i,
  output logic                               m0_gnt_o,
  output logic                               m0_rvalid_o,
  output logic [31:0]                        m0_rdata_o,
  output logic                               m0_err_o,
  input  logic                               m1_req_i,
  input  logic [31:0]                        m1_addr_i,
  output logic                               m1_gnt_o,
  output logic                               m1_rvalid_o,
  output logic [31:0]                        m1_rdata_o,
  output logic                               m1_err_o,
  output logic                               obi_req_o,
  output logic [31:0]                        obi_addr_o,
  input  logic                               obi_gnt_i,
  input  logic                               obi_rvalid_i,
  input  logic [31:0]                        obi_rdata_i,
  input  logic                               obi_err_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               busy_o,
  output logic                               protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t              state;
  logic                lock_id;
  logic                sel;
  logic                sel_req;
  logic                not_full;
  logic                push;
  logic                pop;
  logic                head_id;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic                id_fifo [MAX_OUTSTANDING];

`ifdef CV32E40P_INSTR_ARB_RR_EN
  logic                prio_m1;
`endif

  // Winner selection: a held (waited) request always keeps the bus.
  always_comb begin
    sel = 1'b0;
    if (state == ST_LOCK) begin
      sel = lock_id;
    end else begin
`ifdef CV32E40P_INSTR_ARB_RR_EN
      if (prio_m1) sel = m1_req_i || !m0_req_i;
      else         sel = !m0_req_i && m1_req_i;
`else
      sel = !m0_req_i && m1_req_i;
`endif
    end
  end

  assign sel_req    = sel ? m1_req_i : m0_req_i;
  // Registered count only: a same-cycle pop never frees a slot for this request.
  assign not_full   = (count < CNT_W'(MAX_OUTSTANDING));
  assign obi_req_o  = sel_req && not_full;
  assign obi_addr_o = sel ? m1_addr_i : m0_addr_i;

  assign m0_gnt_o   = obi_req_o && obi_gnt_i && !sel;
  assign m1_gnt_o   = obi_req_o && obi_gnt_i &&  sel;

  assign push       = obi_req_o && obi_gnt_i;
  // Responses arriving with nothing outstanding are dropped.
  assign pop        = obi_rvalid_i && (count != '0);
  assign head_id    = id_fifo[rptr];

  assign m0_rvalid_o = pop && !head_id;
  assign m1_rvalid_o = pop &&  head_id;
  assign m0_rdata_o  = obi_rdata_i;
  assign m1_rdata_o  = obi_rdata_i;
  assign m0_err_o    = obi_err_i;
  assign m1_err_o    = obi_err_i;

  assign outstanding_o = count;
  assign busy_o        = (count != '0) || obi_req_o;

  // ID storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ARB;
      lock_id        <= 1'b0;
      count          <= '0;
      wptr           <= '0;
      rptr           <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (obi_req_o && !obi_gnt_i) begin
            state   <= ST_LOCK;
            lock_id <= sel;
          end
        end
        ST_LOCK: begin
          if (obi_gnt_i) state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase

      if (push) wptr <= (wptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (obi_rvalid_i && (count == '0)) protocol_err_o <= 1'b1;
    end
  end

`ifdef CV32E40P_INSTR_ARB_RR_EN
  // After serving one master, the other gets priority on the next arbitration.
  always_ff @(posedge clk) begin
    if (rst)       prio_m1 <= 1'b0;
    else if (push) prio_m1 <= !sel;
  end
`endif

endmodule

`default_nettype wire
